// File: rtl/pe_arbiter.sv
// Four-requester arbiter: fixed-priority or round-robin selection with a
// registered one-hot grant held until the owner releases or the hold limit hits.
module pe_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       mode_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       valid_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] gnt_id_q;
  logic       valid_q;
  logic       timeout_q;
  logic [7:0] cnt_q;
  logic [1:0] last_q;

  logic       drop_d;
  logic       limit_d;
  logic [3:0] mask_d;
  logic [1:0] win_d;

  // Winner of a masked vector: highest bit in fixed mode, or first set bit
  // searching last+1, last+2, last+3, last in round-robin mode.
  function automatic logic [1:0] pick(input logic [3:0] m, input logic rr,
                                      input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    w = 2'b00;
    if (!rr) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) w = 2'(i);
      end
    end else begin
      // Descending scan so the nearest position after last wins.
      for (int i = 4; i >= 1; i--) begin
        idx = last + 2'(i);
        if (m[idx]) w = idx;
      end
    end
    return w;
  endfunction

  // Release conditions and the arbitration candidate for the coming edge.
  always_comb begin
    drop_d  = ~req_i[gnt_id_q];
    limit_d = (cnt_q == HOLD_LAST);
    mask_d  = req_i;
    if (state_q == GRANT) mask_d[gnt_id_q] = 1'b0;
    win_d   = pick(mask_d, mode_i, last_q);
  end

  // Grant FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
      last_q    <= 2'b11;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|mask_d) begin
            state_q  <= GRANT;
            gnt_q    <= 4'b0001 << win_d;
            gnt_id_q <= win_d;
            valid_q  <= 1'b1;
            cnt_q    <= 8'd0;
            last_q   <= win_d;
          end
        end
        GRANT: begin
          if (drop_d || limit_d) begin
            // A drop on the limit cycle counts as a normal release.
            timeout_q <= limit_d & ~drop_d;
            cnt_q     <= 8'd0;
            if (|mask_d) begin
              gnt_q    <= 4'b0001 << win_d;
              gnt_id_q <= win_d;
              valid_q  <= 1'b1;
              last_q   <= win_d;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= 4'b0000;
              gnt_id_q <= 2'b00;
              valid_q  <= 1'b0;
            end
          end else begin
            timeout_q <= 1'b0;
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pe_arbiter.sv
module tb_pe_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mode;

  logic [3:0] g8, g2, g3;
  logic [1:0] id8, id2, id3;
  logic       v8, v2, v3;
  logic       t8, t2, t3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .mode_i(mode),
    .gnt_o(g8), .gnt_id_o(id8), .valid_o(v8), .timeout_o(t8));

  pe_arbiter #(.MAX_HOLD(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .mode_i(mode),
    .gnt_o(g2), .gnt_id_o(id2), .valid_o(v2), .timeout_o(t2));

  pe_arbiter #(.MAX_HOLD(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .mode_i(mode),
    .gnt_o(g3), .gnt_id_o(id3), .valid_o(v3), .timeout_o(t3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rr_g [9];
  logic       rr_t [9];
  logic [3:0] h_g  [5];
  logic       h_t  [5];

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    mode = 1'b0;

    // Reset with all requests asserted
    tick();
    tick();
    chk("rst_gnt", {4'b0, g8}, 8'h00);
    chk("rst_id", {6'b0, id8}, 8'h00);
    chk("rst_valid", {7'b0, v8}, 8'h00);
    chk("rst_timeout", {7'b0, t8}, 8'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", {4'b0, g8}, 8'h08);
    chk("post_rst_id", {6'b0, id8}, 8'h03);
    chk("post_rst_valid", {7'b0, v8}, 8'h01);

    // Fixed priority with direct handoff
    do_reset();
    req = 4'b0110; mode = 1'b0;
    tick();
    chk("fp_gnt", {4'b0, g8}, 8'h04);
    chk("fp_id", {6'b0, id8}, 8'h02);
    req = 4'b0010;
    tick();
    chk("fp_handoff_gnt", {4'b0, g8}, 8'h02);
    chk("fp_handoff_id", {6'b0, id8}, 8'h01);
    chk("fp_handoff_to", {7'b0, t8}, 8'h00);
    mode = 1'b1;
    req  = 4'b0000;
    tick();
    chk("fp_idle_gnt", {4'b0, g8}, 8'h00);
    chk("fp_idle_valid", {7'b0, v8}, 8'h00);

    // Round-robin rotation, MAX_HOLD=2
    rr_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
             4'b1000, 4'b1000, 4'b0001};
    rr_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    mode = 1'b1;
    req  = 4'b1111;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", i), {4'b0, g2}, {4'b0, rr_g[i]});
      chk($sformatf("rr_to_%0d", i), {7'b0, t2}, {7'b0, rr_t[i]});
    end

    // Hold limit with a sole requester, MAX_HOLD=3
    h_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    h_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0;
    req  = 4'b0001;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_gnt_%0d", i), {4'b0, g3}, {4'b0, h_g[i]});
      chk($sformatf("hold_to_%0d", i), {7'b0, t3}, {7'b0, h_t[i]});
    end

    // Simultaneous drop and limit, MAX_HOLD=2
    req = 4'b0011; mode = 1'b0;
    do_reset();
    tick();
    chk("sim_first_gnt", {4'b0, g2}, 8'h02);
    tick();
    chk("sim_second_gnt", {4'b0, g2}, 8'h02);
    req = 4'b0001;
    tick();
    chk("sim_handoff_gnt", {4'b0, g2}, 8'h01);
    chk("sim_handoff_to", {7'b0, t2}, 8'h00);

    // Mode change during a grant is ignored until the next arbitration
    req = 4'b1010; mode = 1'b0;
    do_reset();
    tick();
    chk("mode_hold_gnt", {4'b0, g8}, 8'h08);
    mode = 1'b1;
    tick();
    chk("mode_hold_still", {4'b0, g8}, 8'h08);

    // Reset mid-grant then round-robin restart from last=11
    req = 4'b0100; mode = 1'b0;
    do_reset();
    tick();
    chk("mid_gnt", {4'b0, g8}, 8'h04);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", {4'b0, g8}, 8'h00);
    chk("mid_rst_valid", {7'b0, v8}, 8'h00);
    rst  = 1'b0;
    req  = 4'b0101;
    mode = 1'b1;
    tick();
    chk("mid_rr_gnt", {4'b0, g8}, 8'h01);
    chk("mid_rr_id", {6'b0, id8}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
